// File: rtl/uart_rx_drive.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_drive
// Brief    : UART receiver. Two-flop synchroniser, start-edge detection and a
//            mid-bit sampling FSM (START/DATA/PARITY/STOP). Each frame ends in
//            a one-cycle valid strobe carrying data, parity and framing flags.
//            Define UART_RX_MAJORITY_VOTE_EN to take each bit as the 2-of-3
//            vote of the samples around the nominal sample point.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_drive #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_rx_perr,
    output logic                         o_user_rx_ferr,
    output logic                         o_user_rx_busy
);

    localparam int C_DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int C_CNT_W = $clog2(C_DIV);
`ifdef UART_RX_MAJORITY_VOTE_EN
    // The vote is registered one cycle after the last sample, and the FSM
    // consumes it the cycle after that.
    localparam int C_MV_LAT = 2;
`else
    localparam int C_MV_LAT = 0;
`endif
    localparam logic [C_CNT_W-1:0] C_BIT_PT    = C_CNT_W'(C_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_START_PT  = C_CNT_W'(C_DIV / 2 - 1 + C_MV_LAT);
    localparam logic [3:0]         C_LAST_DATA = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0]         C_LAST_STOP = 4'(P_UART_STOP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic                         sync1_q, sync2_q, prev_q;
    logic [C_CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                   bit_q, bit_d;
    logic [P_UART_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                         perr_acc_q, perr_acc_d;
    logic                         ferr_acc_q, ferr_acc_d;
    logic [P_UART_DATA_WIDTH-1:0] data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         perr_q, perr_d;
    logic                         ferr_q, ferr_d;
    logic                         busy_q;
    logic                         w_bit;
    logic                         w_start_edge;
    logic                         w_par_x;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign w_start_edge = prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;
    logic       vote_q;

    // Keep the two previous samples and register the 2-of-3 vote every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= 2'b11;
            vote_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            vote_q <= (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
        end
    end

    assign w_bit = vote_q;
`else
    assign w_bit = sync2_q;
`endif

    // XOR of all data bits and the received parity bit
    assign w_par_x = (^shreg_q) ^ w_bit;

    // Next-state, baud counter and output-strobe logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == C_START_PT) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    // A high line at mid start bit was only a glitch
                    state_d    = w_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == C_BIT_PT) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in from the top
                    shreg_d = {w_bit, shreg_q[P_UART_DATA_WIDTH-1:1]};
                    if (bit_q == C_LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == C_BIT_PT) begin
                    cnt_d      = '0;
                    perr_acc_d = (P_UART_CHECK == 1) ? ~w_par_x : w_par_x;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == C_BIT_PT) begin
                    cnt_d = '0;
                    if (bit_q == C_LAST_STOP) begin
                        // Leave at mid stop bit so the next start edge is caught
                        state_d = S_IDLE;
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                        perr_d  = perr_acc_q;
                        ferr_d  = ferr_acc_q | ~w_bit;
                    end else begin
                        bit_d      = bit_q + 4'd1;
                        ferr_acc_d = ferr_acc_q | ~w_bit;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_user_rx_perr  = perr_q;
    assign o_user_rx_ferr  = ferr_q;
    assign o_user_rx_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_drive.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_drive
// Brief    : Self-checking bench for uart_rx_drive. Two receivers share one
//            clock: channel 0 is 8N1, channel 1 is 8 data, even parity, 2 stop.
//            A frame-level model predicts strobe cycle, busy window and the
//            held data/flags; a per-cycle process compares against it.
//            Honours UART_RX_MAJORITY_VOTE_EN (extra latency, glitch frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_drive;

    localparam int SYS_CLK = 307_200;
    localparam int BAUD    = 9600;
    localparam int DIV     = SYS_CLK / BAUD;   // 32 cycles per bit
    localparam int HALF    = DIV / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 2;
`else
    localparam int MV = 0;
`endif

    typedef struct {
        int         ch;
        int         b0;    // first busy cycle
        int         v;     // strobe cycle (busy ends the cycle before)
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       st;    // 1 = frame produces a strobe
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx;
    logic [7:0] d_o [2];
    logic [1:0] v_o, pe_o, fe_o, b_o;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t eq[$];
    logic [7:0] hd [2];
    logic       hpe [2];
    logic       hfe [2];
    int   nstrobe [2];
    int   last_sc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_drive #(
        .P_SYSTEM_CLK(SYS_CLK), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx[0]),
        .o_user_rx_data(d_o[0]), .o_user_rx_valid(v_o[0]), .o_user_rx_perr(pe_o[0]),
        .o_user_rx_ferr(fe_o[0]), .o_user_rx_busy(b_o[0])
    );

    uart_rx_drive #(
        .P_SYSTEM_CLK(SYS_CLK), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx[1]),
        .o_user_rx_data(d_o[1]), .o_user_rx_valid(v_o[1]), .o_user_rx_perr(pe_o[1]),
        .o_user_rx_ferr(fe_o[1]), .o_user_rx_busy(b_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of both receivers against the frame model
    always @(negedge clk) begin
        logic eb, ev;
        if (!rst_n) begin
            eq.delete();
            for (int ch = 0; ch < 2; ch++) begin
                hd[ch] = 8'h00; hpe[ch] = 1'b0; hfe[ch] = 1'b0;
                chk($sformatf("rst_valid%0d", ch), 32'(v_o[ch]), 0);
                chk($sformatf("rst_busy%0d", ch), 32'(b_o[ch]), 0);
                chk($sformatf("rst_data%0d", ch), 32'(d_o[ch]), 0);
                chk($sformatf("rst_perr%0d", ch), 32'(pe_o[ch]), 0);
                chk($sformatf("rst_ferr%0d", ch), 32'(fe_o[ch]), 0);
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                eb = 1'b0;
                ev = 1'b0;
                foreach (eq[i]) begin
                    if (eq[i].ch == ch) begin
                        if (cyc >= eq[i].b0 && cyc <= eq[i].v - 1) eb = 1'b1;
                        if (cyc == eq[i].v && eq[i].st) begin
                            ev = 1'b1;
                            hd[ch] = eq[i].d; hpe[ch] = eq[i].pe; hfe[ch] = eq[i].fe;
                        end
                    end
                end
                chk($sformatf("valid%0d", ch), 32'(v_o[ch]), 32'(ev));
                chk($sformatf("busy%0d", ch), 32'(b_o[ch]), 32'(eb));
                chk($sformatf("data%0d", ch), 32'(d_o[ch]), 32'(hd[ch]));
                chk($sformatf("perr%0d", ch), 32'(pe_o[ch]), 32'(hpe[ch]));
                chk($sformatf("ferr%0d", ch), 32'(fe_o[ch]), 32'(hfe[ch]));
                if (v_o[ch]) begin
                    nstrobe[ch]++;
                    last_sc[ch] = cyc;
                end
            end
            while (eq.size() > 0 && eq[0].v < cyc) void'(eq.pop_front());
        end
    end

    // Drive one frame; glitch_bit inverts one cycle at mid-bit, abort_bit
    // asserts reset at mid-bit and abandons the frame.
    task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit,
                              input logic sbad, input int gap, input int glitch_bit,
                              input int abort_bit, output int c);
        logic bits [12];
        int   nb;
        exp_t e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (ch == 1) begin bits[nb] = pbit; nb++; end
        for (int s = 0; s < ((ch == 1) ? 2 : 1); s++) begin
            bits[nb] = (s == 0) ? ~sbad : 1'b1;
            nb++;
        end
        @(posedge clk); #1;
        c    = cyc;
        e.ch = ch;
        e.b0 = c + 3;
        e.v  = c + 3 + HALF + (nb - 1) * DIV + MV;
        e.d  = d;
        e.pe = (ch == 1) ? ((^d) ^ pbit) : 1'b0;
        e.fe = sbad;
        e.st = 1'b1;
        eq.push_back(e);
        for (int k = 0; k < nb; k++) begin
            for (int t = 0; t < DIV; t++) begin
                if (k == abort_bit && t == HALF) begin
                    rst_n = 1'b0;
                    rx[ch] = 1'b1;
                    #2;
                    chk("lit_abort_busy", 32'(b_o[ch]), 0);
                    chk("lit_abort_data", 32'(d_o[ch]), 0);
                    repeat (5) begin @(posedge clk); #1; end
                    rst_n = 1'b1;
                    repeat (DIV) begin @(posedge clk); #1; end
                    return;
                end
                rx[ch] = (k == glitch_bit && t == HALF) ? ~bits[k] : bits[k];
                @(posedge clk); #1;
            end
        end
        rx[ch] = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_glitch(input int ch, input int len);
        exp_t e;
        @(posedge clk); #1;
        e.ch = ch; e.b0 = cyc + 3; e.v = cyc + 3 + HALF + MV;
        e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b0; e.st = 1'b0;
        eq.push_back(e);
        rx[ch] = 1'b0;
        repeat (len) begin @(posedge clk); #1; end
        rx[ch] = 1'b1;
        chk("lit_glitch_busy", 32'(b_o[ch]), 1);
        repeat (2 * DIV) begin @(posedge clk); #1; end
    endtask

    initial begin
        int         c;
        int         s0;
        logic [7:0] d;
        logic       pb, sb;
        int         ch, gap;
        rst_n = 1'b0;
        rx    = 2'b11;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end

        // Single clean 8N1 frame
        s0 = nstrobe[0];
        send_frame(0, 8'h55, 1'b0, 1'b0, 8, -1, -1, c);
        chk("lit_55_count", 32'(nstrobe[0] - s0), 1);
        chk("lit_55_latency", 32'(last_sc[0] - c), 32'(307 + MV));
        chk("lit_55_data", 32'(d_o[0]), 32'h55);

        // Short low glitch on idle line: false start, no strobe
        s0 = nstrobe[0];
        send_glitch(0, 4);
        chk("lit_glitch_nostrobe", 32'(nstrobe[0] - s0), 0);

        // Even parity: 0xA5 has four ones, so parity bit 1 is wrong
        send_frame(1, 8'hA5, 1'b1, 1'b0, 8, -1, -1, c);
        chk("lit_a5_perr1", 32'(pe_o[1]), 1);
        chk("lit_a5_latency", 32'(last_sc[1] - c), 32'(371 + MV));
        send_frame(1, 8'hA5, 1'b0, 1'b0, 8, -1, -1, c);
        chk("lit_a5_perr0", 32'(pe_o[1]), 0);
        chk("lit_a5_data", 32'(d_o[1]), 32'hA5);

        // Bad stop bit then a good frame
        send_frame(0, 8'h3C, 1'b0, 1'b1, DIV, -1, -1, c);
        chk("lit_3c_ferr", 32'(fe_o[0]), 1);
        chk("lit_3c_data", 32'(d_o[0]), 32'h3C);
        send_frame(0, 8'h3D, 1'b0, 1'b0, 8, -1, -1, c);
        chk("lit_3d_ferr", 32'(fe_o[0]), 0);

        // Back-to-back, no idle gap
        s0 = nstrobe[0];
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 0, -1, -1, c);
        repeat (DIV) begin @(posedge clk); #1; end
        chk("lit_b2b_count", 32'(nstrobe[0] - s0), 4);
        chk("lit_b2b_last", 32'(d_o[0]), 32'h04);

        // Reset during data bit 4, then a fresh frame
        s0 = nstrobe[0];
        send_frame(0, 8'hF0, 1'b0, 1'b0, 0, -1, 5, c);
        send_frame(0, 8'h81, 1'b0, 1'b0, 8, -1, -1, c);
        chk("lit_81_count", 32'(nstrobe[0] - s0), 1);
        chk("lit_81_data", 32'(d_o[0]), 32'h81);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-cycle inverted glitch at the nominal sample point is voted out
        send_frame(0, 8'hA5, 1'b0, 1'b0, 8, 4, -1, c);
        chk("lit_mv_data", 32'(d_o[0]), 32'hA5);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 8, 9, -1, c);
        chk("lit_mv_ferr", 32'(fe_o[0]), 0);
`endif

        // Randomised frames on both channels
        for (int n = 0; n < 16; n++) begin
            ch  = int'($urandom_range(0, 1));
            d   = 8'($urandom);
            pb  = (^d) ^ ($urandom_range(0, 2) == 0);
            sb  = ($urandom_range(0, 3) == 0);
            gap = sb ? DIV : (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 40)));
            send_frame(ch, d, pb, sb, gap, -1, -1, c);
        end

        repeat (3 * DIV) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
